// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator (640x480 @ 60 Hz by default).
//               Produces Row/Col/display_on for a combinational pattern
//               generator, then re-times the returned colour together with
//               pipeline-delayed HSYNC/VSYNC so every pin changes on the
//               same clock edge. Also emits a once-per-frame frame_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned PIPE_DEPTH  = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic [9:0] Row,
  output logic [9:0] Col,
  output logic       display_on,
  input  logic [5:0] rgb_in,
  output logic [5:0] rgb_out,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       frame_tick
);

  localparam int unsigned c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Refuse to build a configuration whose counters or sums overflow 10 bits
  // or whose pipeline depth is outside the supported range.
  if ((PIPE_DEPTH < 1) || (PIPE_DEPTH > 4) ||
      (c_H_TOTAL < 1) || (c_H_TOTAL > 1023) ||
      (c_V_TOTAL < 1) || (c_V_TOTAL > 1023)) begin : g_param_check
    $error("vga_timing_gen: illegal parameter set");
  end

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;

  logic       w_de;
  logic       w_hs;
  logic       w_vs;
  logic       w_tick;

  logic       w_hs_last;
  logic       w_vs_last;
  logic       w_de_last;
  logic [5:0] w_rgb_last;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [5:0] rgb_out_q, rgb_out_d;
  logic       frame_tick_q, frame_tick_d;

  // Next raster position: column wraps every line, row wraps every frame
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == c_H_LAST) begin
      col_d = '0;
      row_d = (row_q == c_V_LAST) ? '0 : row_q + 10'd1;
    end
  end

  // Raster position registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Raw decode of the current position (sync flags are active-high here)
  assign w_de   = (col_q < c_H_ACT) && (row_q < c_V_ACT);
  assign w_hs   = (col_q >= c_HS_START) && (col_q < c_HS_END);
  assign w_vs   = (row_q >= c_VS_START) && (row_q < c_VS_END);
  assign w_tick = (row_q == c_V_ACT) && (col_q == '0);

  if (PIPE_DEPTH == 1) begin : g_direct
    // The pin registers are the only stage
    assign w_hs_last  = w_hs;
    assign w_vs_last  = w_vs;
    assign w_de_last  = w_de;
    assign w_rgb_last = rgb_in;
  end else begin : g_shift
    localparam int unsigned c_N = PIPE_DEPTH - 1;

    logic [c_N-1:0] hs_q;
    logic [c_N-1:0] vs_q;
    logic [c_N-1:0] de_q;
    logic [5:0]     rgb_q [c_N];

    // Intermediate stages: colour is captured alongside its decode flags
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        hs_q <= '0;
        vs_q <= '0;
        de_q <= '0;
        for (int i = 0; i < int'(c_N); i++) rgb_q[i] <= '0;
      end else begin
        hs_q[0]  <= w_hs;
        vs_q[0]  <= w_vs;
        de_q[0]  <= w_de;
        rgb_q[0] <= rgb_in;
        for (int i = 1; i < int'(c_N); i++) begin
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
          de_q[i]  <= de_q[i-1];
          rgb_q[i] <= rgb_q[i-1];
        end
      end
    end

    assign w_hs_last  = hs_q[c_N-1];
    assign w_vs_last  = vs_q[c_N-1];
    assign w_de_last  = de_q[c_N-1];
    assign w_rgb_last = rgb_q[c_N-1];
  end

  // Pin values: apply sync polarity and force black outside the active area
  assign hsync_d      = w_hs_last ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_d      = w_vs_last ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign rgb_out_d    = w_de_last ? w_rgb_last : 6'd0;
  assign frame_tick_d = w_tick;

  // Final stage: all DAC-facing signals leave the same set of flops
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      rgb_out_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      rgb_out_q    <= rgb_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign Row        = row_q;
  assign Col        = col_q;
  assign display_on = w_de;
  assign HSYNC      = hsync_q;
  assign VSYNC      = vsync_q;
  assign rgb_out    = rgb_out_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
